memory_responder: RTL and testbench
===================================

# memory_responder

Responder end of the datapath–cache request protocol. Accepts instruction-fetch and data load/store requests from the single-cycle datapath, arbitrates them onto one shared single-port RAM port with a ready handshake, and returns `ihit`/`dhit` with load data. Sits between the datapath and main memory in place of the cache hierarchy. Handles halt quiescing and, optionally, load-linked/store-conditional atomics.

## Interface
Parameters:
- `ADDR_W`, 32, address/data width.

Ports:
- `CLK` in 1: clock, all state on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `imemREN` in 1: instruction fetch request.
- `imemaddr` in 32: fetch address.
- `ihit` out 1: fetch complete this cycle.
- `imemload` out 32: fetched word, valid when `ihit`.
- `dmemREN` in 1: data load request.
- `dmemWEN` in 1: data store request.
- `dmemaddr` in 32: data address.
- `dmemstore` in 32: store data.
- `datomic` in 1: marks the current load as LL or the current store as SC.
- `dhit` out 1: data access complete this cycle.
- `dmemload` out 32: load data, or SC result; valid when `dhit`.
- `halt` in 1: datapath halted; sticky once seen.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data, valid with `ramready`.
- `ramready` in 1: RAM completes the current access this cycle.
- `flushed` out 1: responder quiesced after halt.

## Operation
- FSM states: IDLE, DREQ, IREQ, HALTED. Encoding is free.
- **IDLE**
  - `halt` → HALTED.
  - Otherwise `dmemREN|dmemWEN` → DREQ. Data has priority over fetch.
  - Otherwise `imemREN` → IREQ.
  - No RAM strobes in IDLE.
- **DREQ**
  - RAM outputs are combinational: `ramaddr=dmemaddr`, `ramstore=dmemstore`, `ramWEN=dmemWEN`, `ramREN=dmemREN & ~dmemWEN`. WEN wins if both are asserted.
  - On `ramready`: `dhit=1`. `dmemload` = `ramload` for a load, 0 for a store. Next state IDLE.
- **IREQ**
  - `ramaddr=imemaddr`, `ramREN=1`.
  - On `ramready`: `ihit=1`, `imemload=ramload`. Next state IDLE.
- **Withdrawal**
  - If the owning request drops while in DREQ/IREQ, strobes deassert that cycle, no hit is issued, and the next state is IDLE.
  - A higher-priority request arriving mid-IREQ does not preempt.
- **HALTED**
  - All strobes 0, hits 0, `flushed=1`.
  - Left only by `RST`.
  - `halt` seen during DREQ/IREQ is ignored until the access returns to IDLE, so an in-flight access always completes or withdraws first.
- `ihit` and `dhit` are never high together.
- `imemload`/`dmemload` are 0 when their hit is low.

## Timing
- Request seen in IDLE at cycle n → RAM strobes at cycle n+1.
- Hit occurs in the same cycle as `ramready`. Minimum latency is 1 cycle, with no upper bound.
- One IDLE bubble separates back-to-back accesses. A fetch following a data access therefore starts ≥2 cycles after `dhit`.
- Hits are combinational from `ramready` and state; there is no registered data path.
- `RST` values: state IDLE, `ihit=dhit=0`, `imemload=dmemload=0`, all RAM strobes 0, `ramaddr=ramstore=0`, `flushed=0`, link invalid.
- `RST` mid-access: the access is abandoned, and strobes are 0 from the cycle after the reset edge.
- `ramready` outside DREQ/IREQ is ignored.

## Configuration
`MEMORY_RESPONDER_ATOMIC_EN`:

- **Defined:** a link register (`linkvalid`, `linkaddr`) is added.
  - **LL** (`datomic & dmemREN`): completes as a normal load, then sets `linkaddr=dmemaddr`, `linkvalid=1`.
  - **SC** (`datomic & dmemWEN`):
    - If `linkvalid && linkaddr==dmemaddr`: performs the RAM write, and at `dhit` returns `dmemload=1`.
    - Otherwise: `ramWEN` is held 0, `dhit=1` in the first DREQ cycle without waiting for `ramready`, and `dmemload=0`.
    - `linkvalid` clears after any SC.
  - A non-atomic store whose address matches `linkaddr` clears `linkvalid` at its `dhit`.
- **Undefined:** `datomic` is ignored, SC behaves as a plain store with `dmemload=0`, and no link state exists.

## Test plan
- Fetch at 0x0000_0040, `ramready` 3 cycles after strobe, `ramload=0x2002_0005` → `ihit` for exactly one cycle with `imemload=0x2002_0005`; `dhit` stays 0.
- `imemREN` and `dmemREN` raised together, `dmemaddr=0x100` → DREQ served first with `dhit`, then IREQ. `ihit` comes ≥2 cycles after `dhit`.
- Store with `dmemaddr=0x200`, `dmemstore=0xDEAD_BEEF` → `ramWEN=1`, `ramaddr=0x200`, `ramstore=0xDEAD_BEEF`. `dhit` comes with `ramready`, `dmemload=0`.
- `halt` raised mid-IREQ → fetch completes with `ihit`, then IDLE, then HALTED with `flushed=1`. Later requests produce no strobes; `RST` clears `flushed`.
- `RST` during DREQ → all outputs 0 the next cycle and state IDLE. A new fetch is served normally afterwards.
- With `MEMORY_RESPONDER_ATOMIC_EN`:
  - LL 0x300, then SC 0x300 → write performed, `dmemload=1`.
  - LL 0x300, then store 0x300, then SC 0x300 → no `ramWEN`, immediate `dhit`, `dmemload=0`.

Source files
------------

// File: rtl/memory_responder_if.sv
// Datapath/RAM request bundle for memory_responder. The slave modport is the responder's view;
// the master modport is the datapath-plus-RAM side.
interface memory_responder_if #(parameter int ADDR_W = 32);
    logic              imemREN;
    logic [ADDR_W-1:0] imemaddr;
    logic              ihit;
    logic [ADDR_W-1:0] imemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    logic [ADDR_W-1:0] dmemstore;
    logic              datomic;
    logic              dhit;
    logic [ADDR_W-1:0] dmemload;
    logic              halt;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [ADDR_W-1:0] ramstore;
    logic [ADDR_W-1:0] ramload;
    logic              ramready;
    logic              flushed;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, datomic, halt,
               ramload, ramready,
        output ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, flushed
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, datomic, halt,
               ramload, ramready,
        input  ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, flushed
    );
endinterface

// File: rtl/memory_responder.sv
// Arbitrates datapath fetch and data requests onto one RAM port, with halt quiescing.
// Define MEMORY_RESPONDER_ATOMIC_EN to add the LL/SC link register.
module memory_responder #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    memory_responder_if.slave bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, DREQ = 2'd1, IREQ = 2'd2, HALTED = 2'd3} state_e;

    localparam logic [ADDR_W-1:0] SC_OK = ADDR_W'(1);

    state_e            state_q, state_d;
    logic              halt_seen_q, halt_seen_d;
    logic              ihit, dhit, ram_ren, ram_wen, flushed;
    logic [ADDR_W-1:0] imemload, dmemload, ram_addr, ram_store;
    logic              sc_req, sc_fail;

`ifdef MEMORY_RESPONDER_ATOMIC_EN
    logic              linkvalid_q, linkvalid_d;
    logic [ADDR_W-1:0] linkaddr_q, linkaddr_d;

    assign sc_req  = bus.datomic & bus.dmemWEN;
    assign sc_fail = sc_req & ~(linkvalid_q && (linkaddr_q == bus.dmemaddr));

    // Link changes only when a data access completes; any SC or a matching plain store breaks it.
    always_comb begin
        linkvalid_d = linkvalid_q;
        linkaddr_d  = linkaddr_q;
        if (dhit) begin
            if (bus.dmemWEN) begin
                if (sc_req || (bus.dmemaddr == linkaddr_q)) linkvalid_d = 1'b0;
            end else if (bus.datomic) begin
                linkvalid_d = 1'b1;
                linkaddr_d  = bus.dmemaddr;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            linkvalid_q <= 1'b0;
            linkaddr_q  <= '0;
        end else begin
            linkvalid_q <= linkvalid_d;
            linkaddr_q  <= linkaddr_d;
        end
    end
`else
    logic unused_datomic;
    assign unused_datomic = bus.datomic;
    assign sc_req         = 1'b0;
    assign sc_fail        = 1'b0;
`endif

    // Handshake: a request is held by the datapath until its hit; the RAM completes an access in
    // the cycle ramready is high, and the hit is returned combinationally in that same cycle.
    always_comb begin
        state_d     = state_q;
        halt_seen_d = halt_seen_q | bus.halt;
        ihit        = 1'b0;
        dhit        = 1'b0;
        imemload    = '0;
        dmemload    = '0;
        ram_ren     = 1'b0;
        ram_wen     = 1'b0;
        ram_addr    = '0;
        ram_store   = '0;
        flushed     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.halt || halt_seen_q)          state_d = HALTED;
                else if (bus.dmemREN || bus.dmemWEN) state_d = DREQ;
                else if (bus.imemREN)                state_d = IREQ;
            end
            DREQ: begin
                if (!(bus.dmemREN || bus.dmemWEN)) begin
                    state_d = IDLE;
                end else begin
                    ram_addr  = bus.dmemaddr;
                    ram_store = bus.dmemstore;
                    ram_wen   = bus.dmemWEN & ~sc_fail;
                    ram_ren   = bus.dmemREN & ~bus.dmemWEN;
                    if (sc_fail) begin
                        dhit    = 1'b1;
                        state_d = IDLE;
                    end else if (bus.ramready) begin
                        dhit     = 1'b1;
                        dmemload = bus.dmemWEN ? (sc_req ? SC_OK : '0) : bus.ramload;
                        state_d  = IDLE;
                    end
                end
            end
            IREQ: begin
                if (!bus.imemREN) begin
                    state_d = IDLE;
                end else begin
                    ram_addr = bus.imemaddr;
                    ram_ren  = 1'b1;
                    if (bus.ramready) begin
                        ihit     = 1'b1;
                        imemload = bus.ramload;
                        state_d  = IDLE;
                    end
                end
            end
            HALTED:  flushed = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    assign bus.ihit     = ihit;
    assign bus.imemload = imemload;
    assign bus.dhit     = dhit;
    assign bus.dmemload = dmemload;
    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.flushed  = flushed;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_memory_responder.sv
// Cycle-by-cycle vector bench for memory_responder; atomic rows run when
// MEMORY_RESPONDER_ATOMIC_EN is defined.
module tb_memory_responder;
    localparam logic [31:0] Z = 32'h0;

    logic       CLK;
    logic       RST;
    logic [1:0] dbg_state;

    memory_responder_if #(.ADDR_W(32)) bus ();

    memory_responder #(.ADDR_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        rst;
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic        dat;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic        halt;
        logic        rdy;
        logic [31:0] rload;
        logic        e_ihit;
        logic        e_dhit;
        logic [31:0] e_iload;
        logic [31:0] e_dload;
        logic        e_rren;
        logic        e_rwen;
        logic [31:0] e_raddr;
        logic [31:0] e_rstore;
        logic        e_flushed;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(
        input string name, input logic rst,
        input logic iren, input logic [31:0] iaddr,
        input logic dren, input logic dwen, input logic dat,
        input logic [31:0] daddr, input logic [31:0] dstore,
        input logic halt, input logic rdy, input logic [31:0] rload,
        input logic e_ihit, input logic e_dhit,
        input logic [31:0] e_iload, input logic [31:0] e_dload,
        input logic e_rren, input logic e_rwen,
        input logic [31:0] e_raddr, input logic [31:0] e_rstore,
        input logic e_flushed);
        vec_t v;
        v.name = name;   v.rst = rst;     v.iren = iren;   v.iaddr = iaddr;
        v.dren = dren;   v.dwen = dwen;   v.dat = dat;     v.daddr = daddr;
        v.dstore = dstore; v.halt = halt; v.rdy = rdy;     v.rload = rload;
        v.e_ihit = e_ihit; v.e_dhit = e_dhit; v.e_iload = e_iload; v.e_dload = e_dload;
        v.e_rren = e_rren; v.e_rwen = e_rwen; v.e_raddr = e_raddr; v.e_rstore = e_rstore;
        v.e_flushed = e_flushed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver: apply one row after the falling edge, compare before the next rising edge
    task automatic apply_vec(input vec_t v);
        logic [31:0] sb_exp;
        @(negedge CLK);
        RST           = v.rst;
        bus.imemREN   = v.iren;
        bus.imemaddr  = v.iaddr;
        bus.dmemREN   = v.dren;
        bus.dmemWEN   = v.dwen;
        bus.datomic   = v.dat;
        bus.dmemaddr  = v.daddr;
        bus.dmemstore = v.dstore;
        bus.halt      = v.halt;
        bus.ramready  = v.rdy;
        bus.ramload   = v.rload;
        if (v.e_ihit) exp_q.push_back(v.e_iload);
        if (v.e_dhit) exp_q.push_back(v.e_dload);
        #1;
        chk({v.name, ".ihit"},     32'(bus.ihit),    32'(v.e_ihit));
        chk({v.name, ".dhit"},     32'(bus.dhit),    32'(v.e_dhit));
        chk({v.name, ".imemload"}, bus.imemload,     v.e_iload);
        chk({v.name, ".dmemload"}, bus.dmemload,     v.e_dload);
        chk({v.name, ".ramREN"},   32'(bus.ramREN),  32'(v.e_rren));
        chk({v.name, ".ramWEN"},   32'(bus.ramWEN),  32'(v.e_rwen));
        chk({v.name, ".ramaddr"},  bus.ramaddr,      v.e_raddr);
        chk({v.name, ".ramstore"}, bus.ramstore,     v.e_rstore);
        chk({v.name, ".flushed"},  32'(bus.flushed), 32'(v.e_flushed));
        // scoreboard: every observed hit must consume one expected load word
        if (bus.ihit === 1'b1 || bus.dhit === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s.sb: unexpected hit, got 0x%08h expected none", v.name,
                         bus.ihit ? bus.imemload : bus.dmemload);
            end else begin
                sb_exp = exp_q.pop_front();
                chk({v.name, ".sb"}, bus.ihit ? bus.imemload : bus.dmemload, sb_exp);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.imemREN = 1'b0; bus.imemaddr = Z; bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
        bus.datomic = 1'b0; bus.dmemaddr = Z; bus.dmemstore = Z; bus.halt = 1'b0;
        bus.ramready = 1'b0; bus.ramload = Z;

        //            name        rst iren iaddr  dren dwen dat daddr dstore halt rdy rload         ihit dhit iload         dload        rren rwen raddr  rstore flush
        vecs.push_back(mk("rst_hold", 1, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("rst_idle", 0, 0, Z,     0, 0, 0, Z,     Z,     0, 1, 32'h1,         0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        // fetch, ramready three cycles after the strobe
        vecs.push_back(mk("f_req",    0, 1, 32'h40, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("f_wait1",  0, 1, 32'h40, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            1, 0, 32'h40, Z,    0));
        vecs.push_back(mk("f_wait2",  0, 1, 32'h40, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            1, 0, 32'h40, Z,    0));
        vecs.push_back(mk("f_wait3",  0, 1, 32'h40, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            1, 0, 32'h40, Z,    0));
        vecs.push_back(mk("f_hit",    0, 1, 32'h40, 0, 0, 0, Z,    Z,     0, 1, 32'h20020005,  1, 0, 32'h20020005, Z,           1, 0, 32'h40, Z,    0));
        vecs.push_back(mk("f_done",   0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        // data wins over fetch, then one bubble before the fetch
        vecs.push_back(mk("p_req",    0, 1, 32'h44, 1, 0, 0, 32'h100, Z,  0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("p_dhit",   0, 1, 32'h44, 1, 0, 0, 32'h100, Z,  0, 1, 32'h11112222,  0, 1, Z,            32'h11112222, 1, 0, 32'h100, Z,   0));
        vecs.push_back(mk("p_bubble", 0, 1, 32'h44, 0, 0, 0, Z,    Z,     0, 1, 32'h99,        0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("p_ihit",   0, 1, 32'h44, 0, 0, 0, Z,    Z,     0, 1, 32'h33334444,  1, 0, 32'h33334444, Z,           1, 0, 32'h44, Z,    0));
        vecs.push_back(mk("p_done",   0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        // store
        vecs.push_back(mk("s_req",    0, 0, Z, 0, 1, 0, 32'h200, 32'hDEADBEEF, 0, 0, Z,        0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("s_wait",   0, 0, Z, 0, 1, 0, 32'h200, 32'hDEADBEEF, 0, 0, Z,        0, 0, Z,            Z,            0, 1, 32'h200, 32'hDEADBEEF, 0));
        vecs.push_back(mk("s_hit",    0, 0, Z, 0, 1, 0, 32'h200, 32'hDEADBEEF, 0, 1, 32'h55555555, 0, 1, Z,        Z,            0, 1, 32'h200, 32'hDEADBEEF, 0));
        vecs.push_back(mk("s_done",   0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        // REN and WEN together: the write wins
        vecs.push_back(mk("b_req",    0, 0, Z, 1, 1, 0, 32'h204, 32'h0BADF00D, 0, 0, Z,        0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("b_hit",    0, 0, Z, 1, 1, 0, 32'h204, 32'h0BADF00D, 0, 1, 32'h77,   0, 1, Z,            Z,            0, 1, 32'h204, 32'h0BADF00D, 0));
        vecs.push_back(mk("b_done",   0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        // fetch withdrawn mid-access
        vecs.push_back(mk("w_req",    0, 1, 32'h48, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("w_live",   0, 1, 32'h48, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            1, 0, 32'h48, Z,    0));
        vecs.push_back(mk("w_drop",   0, 0, Z,     0, 0, 0, Z,     Z,     0, 1, 32'h1234,      0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("w_idle",   0, 0, Z,     0, 0, 0, Z,     Z,     0, 1, 32'h1234,      0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        // reset in the middle of a load
        vecs.push_back(mk("r_req",    0, 0, Z, 1, 0, 0, 32'h104, Z,       0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("r_live",   0, 0, Z, 1, 0, 0, 32'h104, Z,       0, 0, Z,             0, 0, Z,            Z,            1, 0, 32'h104, Z,   0));
        vecs.push_back(mk("r_rst",    1, 0, Z, 1, 0, 0, 32'h104, Z,       0, 0, Z,             0, 0, Z,            Z,            1, 0, 32'h104, Z,   0));
        vecs.push_back(mk("r_after",  0, 0, Z, 1, 0, 0, 32'h104, Z,       0, 1, 32'h5,         0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("r_dhit",   0, 0, Z, 1, 0, 0, 32'h104, Z,       0, 1, 32'hCAFEF00D,  0, 1, Z,            32'hCAFEF00D, 1, 0, 32'h104, Z,   0));
        vecs.push_back(mk("r_idle",   0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("r_freq",   0, 1, 32'h4C, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("r_fhit",   0, 1, 32'h4C, 0, 0, 0, Z,    Z,     0, 1, 32'h0A0B0C0D,  1, 0, 32'h0A0B0C0D, Z,           1, 0, 32'h4C, Z,    0));
        vecs.push_back(mk("r_fdone",  0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        // halt pulsed mid-fetch: fetch completes, one IDLE cycle, then halted until reset
        vecs.push_back(mk("h_req",    0, 1, 32'h50, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("h_mid",    0, 1, 32'h50, 0, 0, 0, Z,    Z,     1, 0, Z,             0, 0, Z,            Z,            1, 0, 32'h50, Z,    0));
        vecs.push_back(mk("h_hit",    0, 1, 32'h50, 0, 0, 0, Z,    Z,     0, 1, 32'hA5A5A5A5,  1, 0, 32'hA5A5A5A5, Z,           1, 0, 32'h50, Z,    0));
        vecs.push_back(mk("h_idle",   0, 1, 32'h50, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("h_halted", 0, 1, 32'h50, 1, 0, 0, 32'h108, Z,  0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     1));
        vecs.push_back(mk("h_hrdy",   0, 1, 32'h50, 1, 0, 0, 32'h108, Z,  0, 1, 32'h6,         0, 0, Z,            Z,            0, 0, Z,     Z,     1));
        vecs.push_back(mk("h_rst",    1, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     1));
        vecs.push_back(mk("h_clear",  0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("h_freq",   0, 1, 32'h54, 0, 0, 0, Z,    Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("h_fhit",   0, 1, 32'h54, 0, 0, 0, Z,    Z,     0, 1, 32'h0F0F0F0F,  1, 0, 32'h0F0F0F0F, Z,           1, 0, 32'h54, Z,    0));
        vecs.push_back(mk("h_fdone",  0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
`ifdef MEMORY_RESPONDER_ATOMIC_EN
        // LL then SC to the same address succeeds
        vecs.push_back(mk("a_ll_req", 0, 0, Z, 1, 0, 1, 32'h300, Z,       0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("a_ll_hit", 0, 0, Z, 1, 0, 1, 32'h300, Z,       0, 1, 32'h77,        0, 1, Z,            32'h77,       1, 0, 32'h300, Z,   0));
        vecs.push_back(mk("a_i1",     0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("a_sc_req", 0, 0, Z, 0, 1, 1, 32'h300, 32'h12345678, 0, 0, Z,        0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("a_sc_hit", 0, 0, Z, 0, 1, 1, 32'h300, 32'h12345678, 0, 1, Z,        0, 1, Z,            32'h1,        0, 1, 32'h300, 32'h12345678, 0));
        vecs.push_back(mk("a_i2",     0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        // LL, plain store to the linked address, then SC fails immediately
        vecs.push_back(mk("a_ll2_req",0, 0, Z, 1, 0, 1, 32'h300, Z,       0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("a_ll2_hit",0, 0, Z, 1, 0, 1, 32'h300, Z,       0, 1, 32'h88,        0, 1, Z,            32'h88,       1, 0, 32'h300, Z,   0));
        vecs.push_back(mk("a_i3",     0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("a_st_req", 0, 0, Z, 0, 1, 0, 32'h300, 32'h1111, 0, 0, Z,            0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("a_st_hit", 0, 0, Z, 0, 1, 0, 32'h300, 32'h1111, 0, 1, Z,            0, 1, Z,            Z,            0, 1, 32'h300, 32'h1111, 0));
        vecs.push_back(mk("a_i4",     0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("a_scf_req",0, 0, Z, 0, 1, 1, 32'h300, 32'h2222, 0, 0, Z,            0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("a_scf_hit",0, 0, Z, 0, 1, 1, 32'h300, 32'h2222, 0, 0, Z,            0, 1, Z,            Z,            0, 0, 32'h300, 32'h2222, 0));
        vecs.push_back(mk("a_i5",     0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
`else
        // without link support an SC is an ordinary store
        vecs.push_back(mk("n_sc_req", 0, 0, Z, 0, 1, 1, 32'h300, 32'h12345678, 0, 0, Z,        0, 0, Z,            Z,            0, 0, Z,     Z,     0));
        vecs.push_back(mk("n_sc_wait",0, 0, Z, 0, 1, 1, 32'h300, 32'h12345678, 0, 0, Z,        0, 0, Z,            Z,            0, 1, 32'h300, 32'h12345678, 0));
        vecs.push_back(mk("n_sc_hit", 0, 0, Z, 0, 1, 1, 32'h300, 32'h12345678, 0, 1, Z,        0, 1, Z,            Z,            0, 1, 32'h300, 32'h12345678, 0));
        vecs.push_back(mk("n_i1",     0, 0, Z,     0, 0, 0, Z,     Z,     0, 0, Z,             0, 0, Z,            Z,            0, 0, Z,     Z,     0));
`endif

        repeat (2) @(posedge CLK);
        foreach (vecs[i]) apply_vec(vecs[i]);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
